// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_tx and uart_rx.
//   uart_state_e      : FSM state encoding, common to both directions
//   UART_CLKS_PER_BIT : default clk_3125 cycles per serial bit (~115200 baud)
//   UART_DATA_BITS    : payload bits per frame
//   UART_FRAME_BITS   : start + data + parity + stop
//   uart_even_parity  : parity bit carried by each frame
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'b000,
    StStart  = 3'b001,
    StData   = 3'b010,
    StParity = 3'b011,
    StStop   = 3'b100
  } uart_state_e;

  localparam int unsigned UART_CLKS_PER_BIT = 27;
  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_FRAME_BITS   = 11;

  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO buffering bytes ahead of the UART transmitter.
// Only instantiated when UART_TX_FIFO_EN is defined.
// Ports:
//   clk_3125 : clock
//   rst_n    : asynchronous active-low reset (empties the FIFO)
//   push     : write din (ignored while full)
//   din      : byte to write
//   pop      : drop the head entry (ignored while empty)
//   dout     : head entry, valid while !empty
//   empty    : no entries
//   full     : DEPTH entries held
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_3125,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] din,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      empty,
  output logic                      full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]             count_q;
  logic                      do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCount);
  assign dout    = mem_q[rd_ptr_q];

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_3125) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start(0), 8 data bits MSB-first, even parity, stop(1),
// each bit CLKS_PER_BIT clocks. Bytes are buffered so frames run back-to-back.
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry byte FIFO;
// otherwise a single holding register plus full flag is used.
// Ports:
//   clk_3125 : 3.125 MHz clock
//   rst_n    : asynchronous active-low reset; aborts any frame, drops buffered bytes
//   tx_data  : byte to send, taken when tx_valid && tx_ready
//   tx_valid : upstream has a byte
//   tx_ready : buffer can take a byte (from registered state only)
//   tx       : serial line, idle high, registered
//   tx_busy  : high for every clock of a frame on tx
//   tx_done  : one-clock pulse on the last clock of each stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                      clk_3125,
  input  logic                      rst_n,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      tx,
  output logic                      tx_busy,
  output logic                      tx_done
);

  localparam int unsigned CntW = 6;
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BitIdxFirst = 3'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 63) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be within 4..63");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_state_e               state_q;
  logic [CntW-1:0]           baud_cnt_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      par_q;
  logic                      baud_last;
  logic                      line_bit;

  logic                      buf_push, buf_pop, buf_empty, buf_full;
  logic [UART_DATA_BITS-1:0] buf_dout;

  assign tx_ready  = !buf_full;
  assign buf_push  = tx_valid && tx_ready;
  assign baud_last = (baud_cnt_q == BaudLast);
  // Pop from IDLE, or on the final stop clock so the next start follows with no gap.
  assign buf_pop   = !buf_empty &&
                     ((state_q == StIdle) || ((state_q == StStop) && baud_last));

`ifdef UART_TX_FIFO_EN
  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_3125 (clk_3125),
    .rst_n    (rst_n),
    .push     (buf_push),
    .din      (tx_data),
    .pop      (buf_pop),
    .dout     (buf_dout),
    .empty    (buf_empty),
    .full     (buf_full)
  );
`else
  logic [UART_DATA_BITS-1:0] hold_q;
  logic                      full_q;

  // Push needs !full and pop needs full, so they never coincide here.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else if (buf_push) begin
      hold_q <= tx_data;
      full_q <= 1'b1;
    end else if (buf_pop) begin
      full_q <= 1'b0;
    end
  end

  assign buf_dout  = hold_q;
  assign buf_full  = full_q;
  assign buf_empty = !full_q;
`endif

  // Line level implied by the state being left at this edge.
  always_comb begin
    line_bit = 1'b1;
    unique case (state_q)
      StIdle:   line_bit = 1'b1;
      StStart:  line_bit = 1'b0;
      StData:   line_bit = shift_q[bit_idx_q];
      StParity: line_bit = par_q;
      StStop:   line_bit = 1'b1;
      default:  line_bit = 1'b1;
    endcase
  end

  // Outputs are registered from the current state, so tx/tx_busy/tx_done trail
  // the state register by one clock; this is the second clock of accept-to-start.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx      <= line_bit;
      tx_busy <= (state_q != StIdle);
      tx_done <= (state_q == StStop) && baud_last;

      unique case (state_q)
        StIdle: begin
          if (buf_pop) begin
            shift_q    <= buf_dout;
            par_q      <= uart_even_parity(buf_dout);
            baud_cnt_q <= '0;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= BitIdxFirst;
            state_q    <= StData;
          end else begin
            baud_cnt_q <= baud_cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd0) begin
              state_q <= StParity;
            end else begin
              bit_idx_q <= bit_idx_q - 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CntW'(1);
          end
        end
        StParity: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            state_q    <= StStop;
          end else begin
            baud_cnt_q <= baud_cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            if (buf_pop) begin
              shift_q <= buf_dout;
              par_q   <= uart_even_parity(buf_dout);
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CntW'(1);
          end
        end
        default: begin
          baud_cnt_q <= '0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx. A frame-level model (byte queue + frame position) predicts
// tx/tx_busy/tx_done/tx_ready every clock; a line decoder recovers bytes from tx.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB   = 27;
  localparam int FRAME = UART_FRAME_BITS * CPB;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk_3125 = 1'b0;
  logic       rst_n    = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready, tx, tx_busy, tx_done;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk_3125 (clk_3125),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk_3125 = ~clk_3125;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: buffered bytes, and clocks left in the frame being serialised.
  logic [7:0]  bq[$];
  int          m_rem = 0;
  logic [10:0] m_frame = 11'h7ff;
  logic        e_tx, e_busy, e_done, e_ready;
  int          n_pre, pos;
  bit          pre_ready, do_pop;

  int acc_log[$];
  int start_log[$];
  int done_log[$];
  int rx_log[$];
  int par_log[$];
  int rx_p = -1;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] stim [8];

  // Line order left to right: start, d7..d0, parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b0, b, ^b, 1'b1};
  endfunction

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    acc_log.delete();
    start_log.delete();
    done_log.delete();
    rx_log.delete();
    par_log.delete();
  endtask

  // Checker: one step per clock, 2 time units after the rising edge.
  initial begin
    forever begin
      @(posedge clk_3125);
      #2;
      cyc++;
      if (!rst_n) begin
        bq.delete();
        m_rem   = 0;
        e_tx    = 1'b1;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        e_ready = 1'b1;
        rx_p    = -1;
      end else begin
        n_pre     = bq.size();
        pre_ready = (n_pre < CAP);
        // Outputs show the frame position held during the clock that just ended.
        if (m_rem > 0) begin
          pos    = FRAME - m_rem;
          e_tx   = m_frame[10 - pos / CPB];
          e_busy = 1'b1;
          e_done = (pos == FRAME - 1);
        end else begin
          e_tx   = 1'b1;
          e_busy = 1'b0;
          e_done = 1'b0;
        end
        do_pop = (n_pre > 0) && (m_rem <= 1);
        if (m_rem > 0) m_rem--;
        if (do_pop) begin
          m_frame = frame_of(bq.pop_front());
          m_rem   = FRAME;
        end
        if (tx_valid && pre_ready) begin
          bq.push_back(tx_data);
          acc_log.push_back(cyc);
        end
        e_ready = (bq.size() < CAP);
      end
      chk("tx", tx, e_tx);
      chk("tx_busy", tx_busy, e_busy);
      chk("tx_done", tx_done, e_done);
      chk("tx_ready", tx_ready, e_ready);

      if (tx_done === 1'b1) done_log.push_back(cyc);
      // Line decoder: sample each bit at its centre.
      if (rst_n) begin
        if (rx_p >= 0) begin
          rx_p++;
          if (rx_p == FRAME) rx_p = -1;
        end
        if (rx_p < 0 && tx === 1'b0) begin
          rx_p = 0;
          start_log.push_back(cyc);
        end else if (rx_p > 0 && (rx_p % CPB) == CPB / 2) begin
          if (rx_p / CPB <= 8) begin
            rx_byte = {rx_byte[6:0], tx};
          end else if (rx_p / CPB == 9) begin
            par_log.push_back(int'(tx));
          end else begin
            chk("stop_bit", tx, 1'b1);
            rx_log.push_back(int'(rx_byte));
          end
        end
      end
    end
  end

  // Offer stim[0..n-1] in order, holding tx_valid; junk data while not ready.
  task automatic send_stream(input int n);
    int i = 0;
    int g = 0;
    while (i < n && g < 5000) begin
      @(negedge clk_3125);
      tx_valid = 1'b1;
      if (tx_ready) begin
        tx_data = stim[i];
        i++;
      end else begin
        tx_data = 8'($urandom);
      end
      g++;
    end
    @(negedge clk_3125);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    if (i < n) begin
      total++;
      bad++;
      $display("FAIL send_stream: only %0d of %0d bytes accepted", i, n);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!(m_rem == 0 && bq.size() == 0) && g < 4000) begin
      @(negedge clk_3125);
      g++;
    end
    if (g >= 4000) begin
      total++;
      bad++;
      $display("FAIL wait_idle: still busy after %0d cycles", g);
    end
    repeat (3) @(negedge clk_3125);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 5 clocks.
    repeat (5) @(negedge clk_3125);
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_3125);

    // Single byte A5.
    chk("frame_a5", frame_of(8'hA5), 11'b0_10100101_0_1);
    clear_logs();
    stim[0] = 8'hA5;
    send_stream(1);
    wait_idle();
    chk("a5_latency", at(start_log, 0) - at(acc_log, 0), 2);
    // tx_done is high on the 297th clock of the frame.
    chk("a5_done_pos", at(done_log, 0) - at(start_log, 0), FRAME - 1);
    chk("a5_done_cnt", done_log.size(), 1);
    chk("a5_byte", at(rx_log, 0), 8'hA5);
    chk("a5_par", at(par_log, 0), 0);

    // 07 (odd weight) and 00.
    chk("frame_07", frame_of(8'h07), 11'b0_00000111_1_1);
    clear_logs();
    stim[0] = 8'h07;
    send_stream(1);
    wait_idle();
    chk("b07_byte", at(rx_log, 0), 8'h07);
    chk("b07_par", at(par_log, 0), 1);
    clear_logs();
    stim[0] = 8'h00;
    send_stream(1);
    wait_idle();
    chk("b00_byte", at(rx_log, 0), 8'h00);
    chk("b00_par", at(par_log, 0), 0);
    chk("b00_len", at(done_log, 0) - at(start_log, 0), FRAME - 1);

    // Back-to-back 55, AA, 0F.
    clear_logs();
    stim[0] = 8'h55;
    stim[1] = 8'hAA;
    stim[2] = 8'h0F;
    send_stream(3);
    wait_idle();
    chk("b2b_b0", at(rx_log, 0), 8'h55);
    chk("b2b_b1", at(rx_log, 1), 8'hAA);
    chk("b2b_b2", at(rx_log, 2), 8'h0F);
    chk("b2b_gap1", at(start_log, 1) - at(start_log, 0), FRAME);
    chk("b2b_gap2", at(start_log, 2) - at(start_log, 1), FRAME);
    chk("b2b_done1", at(done_log, 1) - at(done_log, 0), FRAME);
    chk("b2b_done2", at(done_log, 2) - at(done_log, 1), FRAME);
    chk("b2b_done_cnt", done_log.size(), 3);

`ifdef UART_TX_FIFO_EN
    // Overflow: one byte shifting, then five more offered.
    clear_logs();
    stim[0] = 8'h11;
    send_stream(1);
    repeat (3) @(negedge clk_3125);
    stim[0] = 8'h21;
    stim[1] = 8'h22;
    stim[2] = 8'h23;
    stim[3] = 8'h24;
    stim[4] = 8'h25;
    fork
      send_stream(5);
      begin
        repeat (60) @(negedge clk_3125);
        chk("ovf_ready_low", tx_ready, 1'b0);
      end
    join
    wait_idle();
    chk("ovf_cnt", rx_log.size(), 6);
    chk("ovf_b0", at(rx_log, 0), 8'h11);
    for (int k = 1; k < 6; k++) begin
      chk("ovf_bk", at(rx_log, k), 8'h20 + k);
    end
    // The stalled write lands one clock after the pop-at-full edge.
    chk("ovf_refused", at(acc_log, 5) - at(done_log, 0), 1);
`endif

    // tx_valid held with 12 then 34.
    clear_logs();
    stim[0] = 8'h12;
    stim[1] = 8'h34;
    send_stream(2);
    wait_idle();
    chk("hold_b0", at(rx_log, 0), 8'h12);
    chk("hold_b1", at(rx_log, 1), 8'h34);
    chk("hold_gap", at(start_log, 1) - at(start_log, 0), FRAME);
`ifndef UART_TX_FIFO_EN
    chk("hold_acc_gap", at(acc_log, 1) - at(acc_log, 0), 2);
`endif

    // Reset mid-frame with a second byte buffered.
    stim[0] = 8'hC3;
    stim[1] = 8'h3C;
    send_stream(2);
    repeat (100) @(negedge clk_3125);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", tx_busy, 1'b0);
    chk("mid_rst_ready", tx_ready, 1'b1);
    repeat (2) @(negedge clk_3125);
    rst_n = 1'b1;
    clear_logs();
    repeat (400) @(negedge clk_3125);
    chk("mid_rst_nostart", start_log.size(), 0);
    chk("mid_rst_nobyte", rx_log.size(), 0);

    // Recovery after reset.
    stim[0] = 8'h5A;
    send_stream(1);
    wait_idle();
    chk("post_rst_byte", at(rx_log, 0), 8'h5A);
    chk("post_rst_par", at(par_log, 0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
